// File: rtl/comp_mul_pipe.sv
// Pipelined signed complex multiplier o = a*b or a*conj(b), with valid/ready flow control.
// Optional output saturation to OUT_W bits is enabled by defining COMP_MUL_SAT_EN.
module comp_mul_pipe #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 12,
`ifdef COMP_MUL_SAT_EN
    localparam int RW    = OUT_W
`else
    localparam int RW    = 2 * DATA_W + 1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_r,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_r,
    input  logic [DATA_W-1:0] b_i,
    input  logic              i_conj,
    input  logic              i_en,
    output logic              i_rdy,
    output logic [RW-1:0]     o_r,
    output logic [RW-1:0]     o_i,
    output logic              o_vld,
    input  logic              o_rdy,
    output logic              o_ovf
);

    localparam int PW = 2 * DATA_W;
    localparam int FW = PW + 1;

    // A clamp width outside this range would make saturation meaningless.
    if (OUT_W < 2 || OUT_W > 2 * DATA_W + 1) begin : g_bad_out_w
        $error("comp_mul_pipe: OUT_W must lie in [2, 2*DATA_W+1]");
    end

    logic adv;
    logic vld_p0, vld_p1, vld_p2;

    logic signed [DATA_W-1:0] ar_p0, ai_p0, br_p0, bi_p0;
    logic                     conj_p0;

    logic signed [PW-1:0] rr_p1, ii_p1, ir_p1, ri_p1;
    logic                 conj_p1;

    logic signed [FW-1:0] re_full, im_full;

    // One global advance: a stalled output freezes every stage, bubbles included.
    assign adv   = !vld_p2 || o_rdy;
    assign i_rdy = adv;
    assign o_vld = vld_p2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= i_en;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (adv && i_en) begin
            ar_p0   <= $signed(a_r);
            ai_p0   <= $signed(a_i);
            br_p0   <= $signed(b_r);
            bi_p0   <= $signed(b_i);
            conj_p0 <= i_conj;
        end
    end

    // Stage 2: four partial products at full 2*DATA_W precision
    always_ff @(posedge clk) begin
        if (adv && vld_p0) begin
            rr_p1   <= PW'(ar_p0) * PW'(br_p0);
            ii_p1   <= PW'(ai_p0) * PW'(bi_p0);
            ir_p1   <= PW'(ai_p0) * PW'(br_p0);
            ri_p1   <= PW'(ar_p0) * PW'(bi_p0);
            conj_p1 <= conj_p0;
        end
    end

    // Conjugating b flips the sign of every bi term.
    always_comb begin
        if (conj_p1) begin
            re_full = FW'(rr_p1) + FW'(ii_p1);
            im_full = FW'(ir_p1) - FW'(ri_p1);
        end else begin
            re_full = FW'(rr_p1) - FW'(ii_p1);
            im_full = FW'(ir_p1) + FW'(ri_p1);
        end
    end

`ifdef COMP_MUL_SAT_EN
    localparam logic signed [FW-1:0] SAT_MAX = FW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [FW-1:0] SAT_MIN = ~SAT_MAX;

    // Returns {clamped_flag, value} with value narrowed to RW bits.
    function automatic logic [RW:0] sat_clamp(input logic signed [FW-1:0] x);
        if (x > SAT_MAX)
            sat_clamp = {1'b1, SAT_MAX[RW-1:0]};
        else if (x < SAT_MIN)
            sat_clamp = {1'b1, SAT_MIN[RW-1:0]};
        else
            sat_clamp = {1'b0, x[RW-1:0]};
    endfunction

    logic [RW:0] sat_re, sat_im;
    assign sat_re = sat_clamp(re_full);
    assign sat_im = sat_clamp(im_full);

    // Stage 3: add/sub and clamp; ovf is dropped on bubbles so it tracks o_vld
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_r   <= '0;
            o_i   <= '0;
            o_ovf <= 1'b0;
        end else if (adv) begin
            if (vld_p1) begin
                o_r   <= sat_re[RW-1:0];
                o_i   <= sat_im[RW-1:0];
                o_ovf <= sat_re[RW] | sat_im[RW];
            end else begin
                o_ovf <= 1'b0;
            end
        end
    end
`else
    // Stage 3: add/sub at full precision, which can never overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_r <= '0;
            o_i <= '0;
        end else if (adv && vld_p1) begin
            o_r <= re_full;
            o_i <= im_full;
        end
    end

    assign o_ovf = 1'b0;
`endif

endmodule
